// File: rtl/mul_csv_sgn_seq.sv
// ---------------------------------------------------------------------------
// mul_csv_sgn_seq
//   Sequential signed multiplier. The multiplier arrives in carry-save form
//   (XS/XC) and is resolved once at accept time. digitW multiplier bits are
//   retired per cycle into a carry-save accumulator (PS/PC). An optional
//   accumulate mode adds the previous result to the new product.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   in_valid_i   in   operand valid
//   in_ready_o   out  operand accepted when high with in_valid_i (IDLE)
//   XS, XC       in   widthX  carry-save multiplier
//   Y            in   widthY  signed multiplicand
//   acc_i        in   1: add previous PS+PC to this product
//   out_valid_o  out  result valid (DONE)
//   out_ready_i  in   result consumed
//   PS, PC       out  widthX+widthY carry-save result (sum, carry)
// ---------------------------------------------------------------------------
package lau_pkg;
    typedef enum logic {SLOW, FAST} speed_e;
endpackage

module mul_csv_sgn_seq #(
    parameter int             widthX = 8,
    parameter int             widthY = 8,
    parameter int             digitW = 2,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [widthX-1:0]        XS,
    input  logic [widthX-1:0]        XC,
    input  logic [widthY-1:0]        Y,
    input  logic                     acc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [widthX+widthY-1:0] PS,
    output logic [widthX+widthY-1:0] PC
);

    localparam int N   = (widthX + digitW - 1) / digitW;
    localparam int W   = widthX + widthY;
    localparam int XPW = N * digitW;             // multiplier padded to whole digits
    localparam int KW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_reg, state_next;
    logic [widthX-1:0]   x_reg;
    logic [W-1:0]        y_reg;
    logic [W-1:0]        ps_reg, pc_reg;
    logic [KW-1:0]       k_reg;

    logic                last_digit;
    int                  shamt;
    logic [XPW-1:0]      x_ext;
    logic [digitW-1:0]   dig;
    logic signed [digitW:0] dig_s;
    logic [W-1:0]        dig_w;
    logic [W-1:0]        pp;
    logic [W-1:0]        csa_s, csa_c;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid_i)  state_next = BUSY;
            BUSY:    if (last_digit)  state_next = DONE;
            DONE:    if (out_ready_i) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_o  = (state_reg == IDLE);
        out_valid_o = (state_reg == DONE);
    end

    // ---------------- digit selection ----------------
    // The multiplier is sign-extended to a whole number of digits, so a
    // narrow top digit read as digitW bits already carries the sign in its MSB.
    assign x_ext      = XPW'($signed(x_reg));
    assign last_digit = (k_reg == KW'(N - 1));

    always_comb begin
        shamt = int'(k_reg) * digitW;
        dig   = digitW'(x_ext >> shamt);
        // Only the top digit has negative weight on its MSB.
        dig_s = last_digit ? {dig[digitW-1], dig} : {1'b0, dig};
        dig_w = W'(dig_s);
        pp    = (y_reg * dig_w) << shamt;
    end

    // ---------------- 3:2 compressor ----------------
    generate
        if (speed == lau_pkg::FAST) begin : g_csa_vec
            assign csa_s = ps_reg ^ pc_reg ^ pp;
            assign csa_c = ((ps_reg & pc_reg) | (ps_reg & pp) | (pc_reg & pp)) << 1;
        end else begin : g_csa_bit
            assign csa_c[0] = 1'b0;
            for (genvar gi = 0; gi < W; gi++) begin : g_fa
                assign csa_s[gi] = ps_reg[gi] ^ pc_reg[gi] ^ pp[gi];
                // Carry out of the MSB is dropped: the result is mod 2^W.
                if (gi < W - 1) begin : g_carry
                    assign csa_c[gi+1] = (ps_reg[gi] & pc_reg[gi]) |
                                         (ps_reg[gi] & pp[gi]) |
                                         (pc_reg[gi] & pp[gi]);
                end
            end
        end
    endgenerate

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_reg  <= '0;
            y_reg  <= '0;
            ps_reg <= '0;
            pc_reg <= '0;
            k_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid_i) begin
                        // The only carry-propagate add in the block.
                        x_reg <= XS + XC;
                        y_reg <= W'($signed(Y));
                        k_reg <= '0;
                        // acc=1 keeps the previous result as the seed.
                        if (!acc_i) begin
                            ps_reg <= '0;
                            pc_reg <= '0;
                        end
                    end
                end
                BUSY: begin
                    ps_reg <= csa_s;
                    pc_reg <= csa_c;
                    k_reg  <= last_digit ? '0 : k_reg + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign PS = ps_reg;
    assign PC = pc_reg;

endmodule
